// File: rtl/fir_filter_pkg.sv
// ---------------------------------------------------------------------------
// fir_filter_pkg
//
// Shared definitions for the time-multiplexed FIR filter:
//   - datapath widths (sample, product, accumulator)
//   - default tap count and Q1.15 coefficient set
//   - FSM state encoding for the MAC sequencer
//   - sat_round(): accumulator (Q.30 scale) -> Q1.15 output sample
// ---------------------------------------------------------------------------
package fir_filter_pkg;

    localparam int DATABITS = 16;
    localparam int MULBITS  = 32;
    localparam int ACCBITS  = 34;
    localparam int FIR_TAPS = 4;
    localparam int FRACBITS = 15;

    typedef logic signed [DATABITS-1:0] coeff_array_t [FIR_TAPS];

    // Index 0 multiplies the newest sample in the delay line.
    localparam coeff_array_t FIR_COEFFS = '{16'sd16384, 16'sd8192, 16'sd4096, 16'sd2048};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    localparam logic signed [ACCBITS-1:0] ROUND_HALF = ACCBITS'(1) << (FRACBITS - 1);
    localparam logic signed [ACCBITS-1:0] SAT_MAX    = ACCBITS'(32767);
    localparam logic signed [ACCBITS-1:0] SAT_MIN    = ACCBITS'(-32768);

    // Add half an output LSB, then arithmetic-shift, so ties round toward
    // +inf. The accumulator has enough headroom that the addition cannot
    // overflow for any reachable sum.
    function automatic logic signed [DATABITS-1:0] sat_round(input logic signed [ACCBITS-1:0] acc);
        logic signed [ACCBITS-1:0] r;
        r = acc + ROUND_HALF;
        r = r >>> FRACBITS;
        if (r > SAT_MAX) begin
            return 16'sh7fff;
        end else if (r < SAT_MIN) begin
            return 16'sh8000;
        end
        return r[DATABITS-1:0];
    endfunction

endpackage

// File: rtl/muladd.sv
// ---------------------------------------------------------------------------
// muladd
//
// Purely combinational multiply-accumulate step.
//   c_in    : signed Q1.15 coefficient
//   d_in    : signed Q1.15 sample
//   acc_in  : running accumulator (ACCBITS, Q.30 scale)
//   mul_out : raw signed product c_in * d_in (MULBITS)
//   sum_out : acc_in + sign-extended product (ACCBITS)
// ---------------------------------------------------------------------------
module muladd
    import fir_filter_pkg::*;
(
    input  logic signed [DATABITS-1:0] c_in,
    input  logic signed [DATABITS-1:0] d_in,
    input  logic signed [ACCBITS-1:0]  acc_in,
    output logic signed [MULBITS-1:0]  mul_out,
    output logic signed [ACCBITS-1:0]  sum_out
);

    assign mul_out = c_in * d_in;

    // Size cast of a signed operand sign-extends into the accumulator width.
    assign sum_out = acc_in + ACCBITS'(mul_out);

endmodule

// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
//
// Time-multiplexed FIR controller. A sample accepted on the input handshake
// is shifted into a TAPS-deep delay line; the block then walks one muladd
// instance across every coefficient/sample pair (one pair per clock),
// accumulates, and presents the rounded/saturated Q1.15 result on the
// output handshake until the consumer takes it.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    signed Q1.15 input sample
//   in_valid   in_data valid
//   in_ready   block can accept a sample (high only in IDLE)
//   out_data   signed Q1.15 filtered sample (registered)
//   out_valid  out_data valid (registered)
//   out_ready  consumer accepts out_data
// ---------------------------------------------------------------------------
module fir_mac_sequencer
    import fir_filter_pkg::*;
#(
    parameter int TAPS = FIR_TAPS,
    parameter logic signed [DATABITS-1:0] COEFFS [TAPS] = FIR_COEFFS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATABITS-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [DATABITS-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int IDXW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS - 1);

    // Reject configurations where the accumulator could overflow or where
    // the sequencer has nothing to step through.
    generate
        if (ACCBITS < MULBITS + $clog2(TAPS)) begin : g_acc_width_check
            $error("fir_mac_sequencer: ACCBITS too narrow for TAPS products");
        end
        if (TAPS < 2) begin : g_taps_check
            $error("fir_mac_sequencer: TAPS must be at least 2");
        end
    endgenerate

    fir_state_t                 state_q, state_d;
    logic signed [DATABITS-1:0] dl_q [TAPS];
    logic signed [DATABITS-1:0] dl_d [TAPS];
    logic signed [ACCBITS-1:0]  acc_q, acc_d;
    logic [IDXW-1:0]            tap_idx_q, tap_idx_d;
    logic signed [DATABITS-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;

    logic signed [ACCBITS-1:0]  sum_out;
    logic signed [MULBITS-1:0]  mul_unused;

    // The single shared multiplier-accumulator is always pointed at the
    // current tap; its result is only captured while in MAC.
    muladd u_muladd (
        .c_in    (COEFFS[tap_idx_q]),
        .d_in    (dl_q[tap_idx_q]),
        .acc_in  (acc_q),
        .mul_out (mul_unused),
        .sum_out (sum_out)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Next-state and datapath updates. In IDLE a handshake shifts the delay
    // line and clears the accumulator; in MAC each clock folds one tap into
    // the accumulator and the last tap also loads the output register; in
    // OUT everything holds until the consumer takes the sample.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_idx_d   = tap_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int k = 0; k < TAPS; k++) begin
            dl_d[k] = dl_q[k];
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dl_d[0] = in_data;
                    for (int k = 1; k < TAPS; k++) begin
                        dl_d[k] = dl_q[k-1];
                    end
                    acc_d     = '0;
                    tap_idx_d = '0;
                    state_d   = MAC;
                end
            end

            MAC: begin
                acc_d = sum_out;
                if (tap_idx_q == LAST_IDX) begin
                    // Parking the index at zero keeps it inside the table.
                    tap_idx_d   = '0;
                    out_data_d  = sat_round(sum_out);
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    tap_idx_d = tap_idx_q + 1'b1;
                end
            end

            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset discards any partial result and clears the
    // delay line so the next output starts from silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_idx_q   <= tap_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < TAPS; k++) begin
                dl_q[k] <= dl_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_sequencer
//
// Three sequencer instances share clock and reset: one with the default
// coefficients, one with {1,0,0,0} for rounding, one with all 32767 for
// saturation. Each accepted sample pushes the reference-model output onto
// a queue; each observed output pops and compares.
// ---------------------------------------------------------------------------
module tb_fir_mac_sequencer;
    import fir_filter_pkg::*;

    localparam int NDUT = 3;
    localparam int NT   = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic signed [15:0] in_data   [NDUT];
    logic               in_valid  [NDUT];
    logic               in_ready  [NDUT];
    logic signed [15:0] out_data  [NDUT];
    logic               out_valid [NDUT];
    logic               out_ready [NDUT];

    fir_mac_sequencer #(.TAPS(NT), .COEFFS(FIR_COEFFS)) u_dut_def (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    fir_mac_sequencer #(.TAPS(NT), .COEFFS('{16'sd1, 16'sd0, 16'sd0, 16'sd0})) u_dut_rnd (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    fir_mac_sequencer #(.TAPS(NT), .COEFFS('{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767})) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int mcoef [NDUT][NT];
    int mdl   [NDUT][NT];
    int exp_q [$];
    int accept_cyc = 0;
    int last_exp = 0;

    task automatic check_value(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model: shift the sample in, form the exact dot product,
    // round half toward +inf and clamp to Q1.15.
    function automatic int model_accept(input int d, input int sample);
        longint sum;
        longint r;
        for (int k = NT - 1; k > 0; k--) mdl[d][k] = mdl[d][k-1];
        mdl[d][0] = sample;
        sum = 0;
        for (int k = 0; k < NT; k++) sum += longint'(mcoef[d][k]) * longint'(mdl[d][k]);
        r = (sum + 64'sd16384) >>> 15;
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return int'(r);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < NDUT; d++)
            for (int k = 0; k < NT; k++) mdl[d][k] = 0;
        exp_q.delete();
    endtask

    // Drive a sample and hold it until the DUT accepts it (bounded).
    task automatic applyStimulus(input int d, input int sample);
        int waited;
        waited = 0;
        in_data[d]  = 16'(sample);
        in_valid[d] = 1'b1;
        while (in_ready[d] !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready[d] !== 1'b1) begin
            check_value("accept_timeout", 32'(in_ready[d]), 1);
            in_valid[d] = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid[d] = 1'b0;
            accept_cyc = cyc;
            exp_q.push_back(model_accept(d, sample));
        end
    endtask

    // Wait (bounded) for out_valid, then compare data and latency.
    task automatic checkOutput(input int d, input string tag);
        int waited;
        int expv;
        waited = 0;
        while (out_valid[d] !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_value({tag, "_valid"}, 32'(out_valid[d]), 1);
        if (out_valid[d] === 1'b1) begin
            check_value({tag, "_queue"}, (exp_q.size() > 0) ? 32'sd1 : 32'sd0, 1);
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
            last_exp = expv;
            check_value(tag, 32'(out_data[d]), expv);
            check_value({tag, "_latency"}, cyc - accept_cyc, NT);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        mcoef[0] = '{16384, 8192, 4096, 2048};
        mcoef[1] = '{1, 0, 0, 0};
        mcoef[2] = '{32767, 32767, 32767, 32767};
        model_clear();
        for (int d = 0; d < NDUT; d++) begin
            in_data[d]   = '0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end

        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_value("rst_out_valid", 32'(out_valid[d]), 0);
            check_value("rst_out_data", 32'(out_data[d]), 0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < NDUT; d++) check_value("rst_in_ready", 32'(in_ready[d]), 1);

        // Reset mid-MAC: output register holds a nonzero value beforehand
        applyStimulus(0, 12345);
        checkOutput(0, "pre_rst");
        applyStimulus(0, -5000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_value("rst_mac_out_valid", 32'(out_valid[0]), 0);
        check_value("rst_mac_out_data", 32'(out_data[0]), 0);
        model_clear();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_value("rst_mac_in_ready", 32'(in_ready[0]), 1);
        repeat (6) @(posedge clk);
        #1;
        check_value("rst_mac_no_output", 32'(out_valid[0]), 0);

        // Reset while an output is being held
        out_ready[0] = 1'b0;
        applyStimulus(0, 3000);
        checkOutput(0, "pre_rst_out");
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_out_state_valid", 32'(out_valid[0]), 0);
        check_value("rst_out_state_data", 32'(out_data[0]), 0);
        model_clear();
        #2 rst_n = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check_value("rst_out_in_ready", 32'(in_ready[0]), 1);

        // Impulse response with default coefficients
        applyStimulus(0, 16384); checkOutput(0, "imp0");
        applyStimulus(0, 0);     checkOutput(0, "imp1");
        applyStimulus(0, 0);     checkOutput(0, "imp2");
        applyStimulus(0, 0);     checkOutput(0, "imp3");
        applyStimulus(0, 0);     checkOutput(0, "imp4");

        // Rounding: half LSB goes toward +inf
        applyStimulus(1, 16384);  checkOutput(1, "round_pos");
        applyStimulus(1, -16384); checkOutput(1, "round_neg");

        // Saturation in both directions
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 32767);
            checkOutput(2, "sat_pos");
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, -32768);
            checkOutput(2, "sat_neg");
        end

        // Back-pressure: held output, pending input must not be consumed
        out_ready[0] = 1'b0;
        applyStimulus(0, 2000);
        checkOutput(0, "bp_first");
        in_data[0]  = 16'sd1000;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_value("bp_hold_valid", 32'(out_valid[0]), 1);
            check_value("bp_hold_data", 32'(out_data[0]), last_exp);
            check_value("bp_hold_in_ready", 32'(in_ready[0]), 0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check_value("bp_release_valid", 32'(out_valid[0]), 0);
        check_value("bp_release_in_ready", 32'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        accept_cyc = cyc;
        exp_q.push_back(model_accept(0, 1000));
        check_value("bp_accepted", 32'(in_ready[0]), 0);
        checkOutput(0, "bp_accept");

        // Input presented during the final MAC step waits for IDLE
        applyStimulus(0, -7000);
        repeat (3) @(posedge clk);
        #1;
        in_data[0]  = 16'sd777;
        in_valid[0] = 1'b1;
        check_value("hs_mac_in_ready", 32'(in_ready[0]), 0);
        checkOutput(0, "hs_prev");
        check_value("hs_out_in_ready", 32'(in_ready[0]), 0);
        @(posedge clk); #1;
        check_value("hs_idle_valid", 32'(out_valid[0]), 0);
        check_value("hs_idle_in_ready", 32'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        accept_cyc = cyc;
        exp_q.push_back(model_accept(0, 777));
        check_value("hs_accepted", 32'(in_ready[0]), 0);
        checkOutput(0, "hs_accept");

        check_value("queue_drained", exp_q.size(), 0);
        $display("[TB] done at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
